secure_serdes_decryptor_core: RTL
=================================

// Module: secure_serdes_decryptor_core
// PURPOSE
//  Receive-side counterpart of the serial XOR encryptor: captures an 8-bit serial cipher frame plus the matching serial B stream.
//  Recovers plaintext as plain = C ^ B ^ key_byte and presents the byte on a valid/ready interface.
//  Sits between the serial link input pins and the byte-wide consumer logic.
// PARAMETERS
//  KEY_W      128  key width in bits; must be a multiple of 8
//  BYTE_W     8    frame length in bits; fixed at 8
//  KEY_BYTES  16   KEY_W/8; number of selectable key bytes (localparam)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       reset; asynchronous, active-low
//  start        in   1       frame start strobe, sampled in IDLE/VALID
//  cipher_in    in   1       serial cipher bit, MSB first
//  b_bit        in   1       serial B bit, MSB first, aligned with cipher_in
//  key          in   KEY_W   static key
//  plain_byte   out  8       recovered byte; stable while plain_valid=1
//  plain_valid  out  1       byte available
//  plain_ready  in   1       consumer accepts; handshake when valid&ready
//  busy         out  1       1 in SHIFT or DECRYPT
//  overrun      out  1       sticky: start was lost while a byte was pending
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; plain_byte=0, plain_valid=0, busy=0, overrun=0; bit counter=0; key index=0.
//  States: IDLE -> SHIFT -> DECRYPT -> VALID -> IDLE|SHIFT.
//  - IDLE: start=1 at edge E0 -> SHIFT; clear shift regs and bit counter.
//  - SHIFT: each edge shifts in {sr[6:0],cipher_in} and {br[6:0],b_bit}; bits are sampled on edges E1..E8.
//    Counter 0..7; after 8th sample -> DECRYPT.
//  - DECRYPT: plain_byte <= csr ^ bsr ^ key_byte; -> VALID. plain_valid=1 from edge E10 (latency 10 clocks start->valid).
//  - VALID: hold plain_byte/plain_valid until plain_ready=1.
//    * ready=1, start=0 -> IDLE, valid drops next edge.
//    * ready=1, start=1 -> handshake completes and the new frame is accepted; -> SHIFT directly (back-to-back, no bubble).
//    * ready=0, start=1 -> start dropped, overrun<=1.
//  - start in SHIFT/DECRYPT: ignored, no flag.
//  - cipher_in/b_bit outside SHIFT: don't care.
//  - overrun clears only on reset.
//  - Reset mid-frame: partial byte discarded, no valid produced.
//  - All arithmetic is bitwise XOR on 8 bits; no carries.
// CONFIGURATION
//  Macro SECURE_SERDES_KEY_ROLL_EN:
//  - Defined: key_byte = key[8*idx +: 8]; idx (4 bits) increments on each DECRYPT and wraps 15->0; reset idx=0.
//    The transmitter must use the same schedule.
//  - Undefined: key_byte = key[7:0] for every frame, matching the current fixed-key encryptor; no idx register.
// STRUCTURE
//  - Package secure_serdes_pkg: state enum (IDLE, SHIFT, DECRYPT, VALID), BYTE_W, default key constant 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234.
//  - Sub-module serdes_rx_shifter: dual 8-bit MSB-first shift register with clear, shift enable and bit counter; it raises last_bit on the 8th sample.
//  - FSM, key select and output register live in the top.
// TESTING (default key, key[7:0]=0x34, key[15:8]=0x12)
//  1. start, cipher 0xAD, B 0x3C, ready=1 -> plain_byte=0xA5, valid exactly 1 cycle at E10.
//  2. Same frame with ready=0 for 5 cycles -> 0xA5 held stable; valid drops one edge after ready rises; overrun=0.
//  3. Pending byte with ready=0, pulse start -> overrun=1 and stays 1; frame not captured; state stays VALID.
//  4. Back-to-back: ready=1 and start=1 at the VALID edge -> second frame (C 0x34, B 0x00) yields 0x00 with no bubble cycle.
//  5. rst_n low at the 4th SHIFT bit -> all outputs 0 immediately; next full frame decodes correctly.
//  6. With SECURE_SERDES_KEY_ROLL_EN, two frames C 0xAD/B 0x3C -> 0xA5 then 0x83; 17th frame uses key[7:0] again.

Source files
------------

// File: rtl/secure_serdes_pkg.sv
// Shared types and constants for the serial XOR decryptor.
// Contents:
//   BYTE_W / CNT_W   frame length and bit-counter width
//   KEY_W_DEFAULT    default key width
//   DEFAULT_KEY      reference key shared with the encryptor side
//   state_t          receive FSM states
//   frame_t          captured cipher/B byte pair
//   decrypt_byte     plain = C ^ B ^ key_byte
package secure_serdes_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = $clog2(BYTE_W);
    localparam int unsigned KEY_W_DEFAULT = 128;

    localparam logic [KEY_W_DEFAULT-1:0] DEFAULT_KEY =
        128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DECRYPT = 2'd2,
        VALID   = 2'd3
    } state_t;

    // One received frame: cipher byte and its matching B byte.
    typedef struct packed {
        logic [BYTE_W-1:0] c;
        logic [BYTE_W-1:0] b;
    } frame_t;

    // Pure bitwise XOR, no carries.
    function automatic logic [BYTE_W-1:0] decrypt_byte(input frame_t            f,
                                                      input logic [BYTE_W-1:0] k);
        return f.c ^ f.b ^ k;
    endfunction

endpackage

// File: rtl/serdes_rx_shifter.sv
// Dual 8-bit MSB-first receive shift register with bit counter.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           synchronous clear of both registers and the counter (wins over shift)
//   shift_en      shift one bit into each register this edge
//   cipher_in     serial cipher bit
//   b_bit         serial B bit, aligned with cipher_in
//   csr, bsr      captured cipher / B bytes
//   last_bit_c    combinational: the current edge takes the 8th sample
module serdes_rx_shifter
    import secure_serdes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              cipher_in,
    input  logic              b_bit,
    output logic [BYTE_W-1:0] csr,
    output logic [BYTE_W-1:0] bsr,
    output logic              last_bit_c
);

    logic [CNT_W-1:0] bit_cnt;

    // Shift registers and counter; counter wraps 7->0 on the 8th sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr     <= '0;
            bsr     <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            csr     <= '0;
            bsr     <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            csr     <= {csr[BYTE_W-2:0], cipher_in};
            bsr     <= {bsr[BYTE_W-2:0], b_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign last_bit_c = shift_en && (bit_cnt == CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/secure_serdes_decryptor_core.sv
// Receive-side serial XOR decryptor: captures an 8-bit cipher frame and the
// aligned B stream, recovers plain = C ^ B ^ key_byte and offers it on a
// valid/ready interface.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         frame start strobe (honoured in IDLE, or in VALID with ready)
//   cipher_in     serial cipher bit, MSB first
//   b_bit         serial B bit, MSB first
//   key           static key
//   plain_byte    recovered byte, stable while plain_valid
//   plain_valid   byte available
//   plain_ready   consumer accept
//   busy          frame being shifted or decrypted
//   overrun       sticky: a start arrived while a byte was pending and unaccepted
// Configuration:
//   SECURE_SERDES_KEY_ROLL_EN  defined: key byte index advances on every frame
//                              (wraps after KEY_W/8 frames); undefined: key[7:0] always.
module secure_serdes_decryptor_core
    import secure_serdes_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cipher_in,
    input  logic              b_bit,
    input  logic [KEY_W-1:0]  key,
    output logic [BYTE_W-1:0] plain_byte,
    output logic              plain_valid,
    input  logic              plain_ready,
    output logic              busy,
    output logic              overrun
);

    state_t            state;
    state_t            state_nxt;

    logic [BYTE_W-1:0] csr;
    logic [BYTE_W-1:0] bsr;
    logic              last_bit_c;
    frame_t            rx_frame;
    logic [BYTE_W-1:0] key_byte;

    logic              sh_clr_c;
    logic              sh_en_c;
    logic              load_c;
    logic              ovr_set_c;

    serdes_rx_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sh_clr_c),
        .shift_en   (sh_en_c),
        .cipher_in  (cipher_in),
        .b_bit      (b_bit),
        .csr        (csr),
        .bsr        (bsr),
        .last_bit_c (last_bit_c)
    );

    assign rx_frame.c = csr;
    assign rx_frame.b = bsr;

`ifdef SECURE_SERDES_KEY_ROLL_EN
    localparam int unsigned KEY_BYTES = KEY_W / BYTE_W;
    localparam int unsigned IDX_W     = $clog2(KEY_BYTES);
    localparam int unsigned KSEL_W    = $clog2(KEY_W);

    logic [IDX_W-1:0]  key_idx;
    logic [KSEL_W-1:0] key_lsb;

    // Rolling key index; advances once per decrypted frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_idx <= '0;
        end else if (load_c) begin
            key_idx <= key_idx + IDX_W'(1);
        end
    end

    assign key_lsb  = KSEL_W'({key_idx, 3'b000});
    assign key_byte = key[key_lsb +: BYTE_W];
`else
    logic unused_key_hi;

    // Fixed-key build: only the low key byte participates.
    assign key_byte      = key[BYTE_W-1:0];
    assign unused_key_hi = ^key[KEY_W-1:BYTE_W];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit_c) begin
                    state_nxt = DECRYPT;
                end
            end
            DECRYPT: begin
                state_nxt = VALID;
            end
            VALID: begin
                // Handshake with start goes straight back into SHIFT, no bubble.
                if (plain_ready) begin
                    state_nxt = start ? SHIFT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        sh_clr_c  = 1'b0;
        sh_en_c   = 1'b0;
        load_c    = 1'b0;
        ovr_set_c = 1'b0;
        case (state)
            IDLE: begin
                sh_clr_c = start;
            end
            SHIFT: begin
                sh_en_c = 1'b1;
            end
            DECRYPT: begin
                load_c = 1'b1;
            end
            VALID: begin
                sh_clr_c  = plain_ready && start;
                ovr_set_c = !plain_ready && start;
            end
            default: begin
                sh_clr_c = 1'b0;
            end
        endcase
    end

    // Registered outputs; valid/busy follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plain_byte  <= '0;
            plain_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            plain_valid <= (state_nxt == VALID);
            busy        <= (state_nxt == SHIFT) || (state_nxt == DECRYPT);
            if (load_c) begin
                plain_byte <= decrypt_byte(rx_frame, key_byte);
            end
            if (ovr_set_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
